bcd_batch_converter: RTL

Streaming, multi-lane binary-to-BCD converter, the parametrised successor to the fixed ten-instance encoder batch. It accepts binary values over a valid/ready stream and dispatches them round-robin to `LANES` double-dabble engines. Results return over a second valid/ready stream in strict input order, each with an overflow flag. It sits between any binary producer and the display/readout path, replacing hard-wired input arrays and a global AND-of-done.

---
 rtl/bcdc_pkg.sv | 27 ++
 rtl/bcd_lane.sv | 81 ++++++++
 rtl/bcd_batch_converter.sv | 98 +++++++++
 3 files changed

// File: rtl/bcdc_pkg.sv
// bcdc_pkg: shared types and helpers for the batch BCD converter.
// Lane state enum, digit width, add-3 adjust, parameter sanity check.
package bcdc_pkg;

    typedef enum logic [1:0] {
        LANE_IDLE,
        LANE_SHIFT,
        LANE_DONE
    } lane_state_e;

    localparam int DIGIT_W = 4;

    function automatic logic [DIGIT_W-1:0] add3_adjust(
        input logic [DIGIT_W-1:0] d
    );
        return (d >= DIGIT_W'(5)) ? d + DIGIT_W'(3) : d;
    endfunction

    function automatic bit bcd_capacity_ok(
        input int in_w,
        input int digits,
        input int lanes
    );
        return (in_w >= 2) && (digits >= 1) && (lanes >= 1);
    endfunction

endpackage

// File: rtl/bcd_lane.sv
// bcd_lane: one double-dabble engine, IN_W iterations per conversion.
// Ports: clock/reset, load/collect strobes, operand+sign in; state, bcd, ovf, neg out.
module bcd_lane
    import bcdc_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      collect,
    input  logic [IN_W-1:0]           operand,
    input  logic                      sign,
    output lane_state_e               state,
    output logic [DIGIT_W*DIGITS-1:0] bcd,
    output logic                      ovf,
    output logic                      neg
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    lane_state_e     state_q;
    lane_state_e     state_d;
    logic [IN_W-1:0] op_q;
    logic [CW-1:0]   cnt_q;
    logic [BW-1:0]   bcd_q;
    logic [BW-1:0]   adj;
    logic            ovf_q;
    logic            neg_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LANE_IDLE:  if (load) state_d = LANE_SHIFT;
            LANE_SHIFT: if (cnt_q == CW'(IN_W - 1)) state_d = LANE_DONE;
            LANE_DONE:  if (collect) state_d = LANE_IDLE;
            default:    state_d = LANE_IDLE;
        endcase
    end

    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            adj[i*DIGIT_W +: DIGIT_W] = add3_adjust(bcd_q[i*DIGIT_W +: DIGIT_W]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LANE_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == LANE_IDLE && load) begin
                op_q  <= operand;
                cnt_q <= '0;
                bcd_q <= '0;
                ovf_q <= 1'b0;
                neg_q <= sign;
            end else if (state_q == LANE_SHIFT) begin
                // digits above DIGITS are dropped; any bit lost is sticky ovf
                bcd_q <= {adj[BW-2:0], op_q[IN_W-1]};
                op_q  <= {op_q[IN_W-2:0], 1'b0};
                cnt_q <= cnt_q + CW'(1);
                ovf_q <= ovf_q | adj[BW-1];
            end
        end
    end

    assign state = state_q;
    assign bcd   = bcd_q;
    assign ovf   = ovf_q;
    assign neg   = neg_q;

endmodule

// File: rtl/bcd_batch_converter.sv
// bcd_batch_converter: round-robin multi-lane binary-to-BCD stream, in-order results.
// Ports: clock, reset (async low), in_* / out_* valid-ready streams, busy. Macro BCDC_SIGNED_EN.
module bcd_batch_converter
    import bcdc_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 10,
    parameter int LANES  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                      out_ovf,
    output logic                      out_neg,
    output logic                      busy
);

    localparam int BW = DIGIT_W * DIGITS;
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

    if (!bcd_capacity_ok(IN_W, DIGITS, LANES)) begin : g_bad_params
        $error("bcd_batch_converter: bad IN_W/DIGITS/LANES");
    end

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    lane_state_e     st   [LANES];
    logic [BW-1:0]   lbcd [LANES];
    logic            lovf [LANES];
    logic            lneg [LANES];
    logic [IN_W-1:0] operand;
    logic            sign;
    logic            in_fire;
    logic            out_fire;

`ifdef BCDC_SIGNED_EN
    // -2^(IN_W-1) negates to itself, which is the right unsigned magnitude
    assign sign    = in_data[IN_W-1];
    assign operand = sign ? (~in_data + IN_W'(1)) : in_data;
`else
    assign sign    = 1'b0;
    assign operand = in_data;
`endif

    assign in_ready  = (st[wr_ptr] == LANE_IDLE);
    assign out_valid = (st[rd_ptr] == LANE_DONE);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bcd_lane #(
            .IN_W  (IN_W),
            .DIGITS(DIGITS)
        ) u_lane (
            .clock  (clock),
            .reset  (reset),
            .load   (in_fire && (wr_ptr == PW'(i))),
            .collect(out_fire && (rd_ptr == PW'(i))),
            .operand(operand),
            .sign   (sign),
            .state  (st[i]),
            .bcd    (lbcd[i]),
            .ovf    (lovf[i]),
            .neg    (lneg[i])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (in_fire) begin
                wr_ptr <= (wr_ptr == PW'(LANES - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (out_fire) begin
                rd_ptr <= (rd_ptr == PW'(LANES - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (st[i] != LANE_IDLE) busy = 1'b1;
        end
    end

    assign out_bcd = lbcd[rd_ptr];
    assign out_ovf = lovf[rd_ptr];
    assign out_neg = lneg[rd_ptr];

endmodule
